pattern_gen: RTL
================

# pattern_gen

Stimulus generator for the level-translator/inverter tester. It walks a fixed sequence of test patterns onto the device-under-test inputs. For each pattern it holds the drive through a settle window, then asserts a compare window, and presents the expected DUT output alongside. Downstream, `diff = (observed ^ expected) & {WIDTH{check_en}}` feeds the per-bit persistence checker, which raises sticky fault flags.

## Interface
- WIDTH, 1: number of DUT channels; legal 1..64
- SETTLE, 2: cycles per pattern with `check_en` low after a drive change; legal 1..65535
- HOLD, 4: cycles per pattern with `check_en` high; legal 1..65535
- INVERT, 1: 1 means expected = ~drive (inverting DUT); 0 means expected = drive
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  terminate the run immediately; honoured in any state
- drive  out  WIDTH  pattern applied to DUT inputs
- expected  out  WIDTH  expected DUT outputs; always equals `drive ^ {WIDTH{INVERT}}`, combinational from `drive`
- check_en  out  1  compare window; checker input is gated by this signal
- pat_idx  out  PW  index of the current pattern, 0-based; PW = clog2(2*WIDTH+4)
- busy  out  1  high from the cycle after `start` is accepted until the run ends
- done  out  1  sticky; set at normal completion, cleared by `start`, `abort` or `rst`

## Operation
- Pattern sequence, NPAT = 2*WIDTH+4 entries:
  - idx 0: all-zero
  - idx 1: all-one
  - idx 2..WIDTH+1: walking one, bit 0 first
  - idx WIDTH+2..2*WIDTH+1: walking zero, bit 0 first
  - idx 2*WIDTH+2: ...0101
  - idx 2*WIDTH+3: ...1010
- Patterns are computed from `pat_idx`; no ROM.
- FSM states: IDLE, SETTLE, CHECK.
  - IDLE + start: drive <= pattern 0; pat_idx <= 0; cnt <= 0; busy <= 1; done <= 0; go to SETTLE.
  - SETTLE: cnt increments. When cnt == SETTLE-1: cnt <= 0, check_en <= 1, go to CHECK.
  - CHECK: cnt increments. When cnt == HOLD-1:
    - If pat_idx < NPAT-1: pat_idx++, drive <= next pattern, check_en <= 0, go to SETTLE.
    - Otherwise: drive <= 0, pat_idx <= 0, check_en <= 0, busy <= 0, done <= 1, go to IDLE.
- `abort` in any state: go to IDLE; drive, pat_idx, check_en, busy and done all go to 0.
- `abort` and `start` in the same cycle: abort wins, and the start is dropped.
- `start` while busy is ignored; there is no queueing.
- `cnt` is 16-bit, unsigned, and never wraps, because it clears at the terminal count.
- Reset values: drive 0, pat_idx 0, check_en 0, busy 0, done 0, state IDLE. `expected` is therefore {WIDTH{INVERT}}.
- `rst` mid-run has the same effect as `abort` but takes precedence over everything.

## Timing
- `start` sampled at edge k: drive shows pattern 0 after edge k.
- `check_en` rises after edge k+SETTLE and falls after edge k+SETTLE+HOLD. The next pattern is applied on that same edge.
- `drive` never changes while `check_en` is high. `check_en` is low in the first cycle of every new pattern.
- Each pattern occupies exactly SETTLE+HOLD cycles. `busy` is high for NPAT*(SETTLE+HOLD) cycles.
- `done` rises on the same edge that `busy` falls.
- All outputs are registered except `expected`, which is an XOR of registered `drive`.
- The checker's persistence threshold must be ≤ HOLD for a stuck channel to be flagged. The SETTLE window absorbs DUT propagation delay plus the input synchronizer.

## Structure
- Shared tester package holds:
  - state encoding constants: IDLE=0, SETTLE=1, CHECK=2
  - NPAT and PW as functions of WIDTH
  - pattern-class boundary constants
- Sub-module `pattern_rom`: purely combinational map idx -> pattern. It is parameterised by WIDTH and reusable by the bench scoreboard.
- The FSM, counter and output registers stay in `pattern_gen`.

## Test plan
All scenarios use WIDTH=4, SETTLE=2, HOLD=3, INVERT=1 unless stated.
- Reset then idle 10 cycles -> drive=0000, expected=1111, check_en=0, busy=0, done=0.
- Single start pulse:
  - drive sequence is 0000, 1111, 0001, 0010, 0100, 1000, 1110, 1101, 1011, 0111, 0101, 1010, each held 5 cycles.
  - check_en is high in cycles 3-5 of each pattern.
  - busy is high 60 cycles, then done=1 and drive=0000.
- Abort asserted during pattern 6 CHECK -> next cycle drive=0000, check_en=0, busy=0, done=0. A subsequent start restarts at pat_idx 0.
- start held high continuously -> second run begins the cycle after done sets, and done clears. start pulses mid-run have no effect on pat_idx or timing.
- start and abort asserted together in IDLE -> remains IDLE, busy stays 0.
- INVERT=0, WIDTH=1, SETTLE=1, HOLD=1 -> 6 patterns (0,1,1,0,1,0) at 2 cycles each, expected==drive. Loopback of drive into the checker with threshold 1 yields no flag; forcing one bit stuck yields a flag.

Source files
------------

// File: rtl/pattern_gen_pkg.sv
// Shared tester package: FSM state encoding, pattern-table sizing and
// the index boundaries between the pattern classes.
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2
  } state_t;

  // Width of the per-pattern cycle counter.
  localparam int CNT_W = 16;

  // Fixed positions at the head of the sequence.
  localparam int IDX_ALL_ZERO    = 0;
  localparam int IDX_ALL_ONE     = 1;
  localparam int IDX_WALK1_FIRST = 2;

  // Total number of patterns for a given channel count.
  function automatic int npat(input int width);
    return 2 * width + 4;
  endfunction

  // Width of the pattern index for a given channel count.
  function automatic int pat_w(input int width);
    return $clog2(2 * width + 4);
  endfunction

  // First walking-zero index.
  function automatic int walk0_first(input int width);
    return width + 2;
  endfunction

  // Index of the ...0101 pattern.
  function automatic int alt01_idx(input int width);
    return 2 * width + 2;
  endfunction

  // Index of the ...1010 pattern.
  function automatic int alt10_idx(input int width);
    return 2 * width + 3;
  endfunction

endpackage

// File: rtl/pattern_gen_rom.sv
// Purely combinational map from pattern index to pattern value.
// Every pattern is derived from the index arithmetically; there is no table.
module pattern_rom
  import pattern_gen_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int PW    = pat_w(WIDTH)
) (
  input  logic [PW-1:0]    idx,
  output logic [WIDTH-1:0] pattern
);

  localparam int WALK0_FIRST = walk0_first(WIDTH);
  localparam int WALK0_LAST  = 2 * WIDTH + 1;
  localparam int WALK1_LAST  = WIDTH + 1;
  localparam int ALT01_IDX   = alt01_idx(WIDTH);
  localparam int ALT10_IDX   = alt10_idx(WIDTH);

  int k;

  // Decode the index into its pattern class and build the bit vector.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    pattern = '0;
    k       = int'(idx);
    for (int i = 0; i < WIDTH; i++) begin
      if (k == IDX_ALL_ONE) begin
        pattern[i] = 1'b1;
      end else if (k >= IDX_WALK1_FIRST && k <= WALK1_LAST) begin
        pattern[i] = (i == k - IDX_WALK1_FIRST);
      end else if (k >= WALK0_FIRST && k <= WALK0_LAST) begin
        pattern[i] = (i != k - WALK0_FIRST);
      end else if (k == ALT01_IDX) begin
        pattern[i] = (i % 2 == 0);
      end else if (k == ALT10_IDX) begin
        pattern[i] = (i % 2 == 1);
      end
    end
  end

endmodule

// File: rtl/pattern_gen.sv
// Stimulus generator for the level-translator/inverter tester. Walks the
// pattern sequence onto the DUT inputs, holding each pattern through a
// settle window followed by a compare window flagged by check_en.
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 2,
  parameter int HOLD   = 4,
  parameter bit INVERT = 1'b1,
  localparam int NPAT  = npat(WIDTH),
  localparam int PW    = pat_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] drive,
  output logic [WIDTH-1:0] expected,
  output logic             check_en,
  output logic [PW-1:0]    pat_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD - 1);
  localparam logic [PW-1:0]    LAST_IDX    = PW'(NPAT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    rom_idx;
  logic [WIDTH-1:0] rom_pat;

  // The ROM looks up whichever pattern is loaded next: pattern 0 when a
  // run starts from IDLE, otherwise the successor of the current one.
  assign rom_idx = (state == ST_IDLE) ? '0 : pat_idx + PW'(1);

  pattern_rom #(
    .WIDTH (WIDTH),
    .PW    (PW)
  ) u_rom (
    .idx     (rom_idx),
    .pattern (rom_pat)
  );

  // Expected DUT response follows drive directly, inverted for an inverting DUT.
  assign expected = drive ^ {WIDTH{INVERT}};

  // Sequencer FSM: settle/check timing, pattern stepping and status flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (rst || abort) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      drive    <= '0;
      pat_idx  <= '0;
      check_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            drive   <= rom_pat;
            pat_idx <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            state   <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt      <= '0;
            check_en <= 1'b1;
            state    <= ST_CHECK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_CHECK: begin
          if (cnt == HOLD_LAST) begin
            cnt      <= '0;
            check_en <= 1'b0;
            if (pat_idx != LAST_IDX) begin
              pat_idx <= pat_idx + PW'(1);
              drive   <= rom_pat;
              state   <= ST_SETTLE;
            end else begin
              drive   <= '0;
              pat_idx <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
